// File: rtl/pattern_tx.sv
// rtl/pattern_tx.sv - serializes a captured bit pattern MSB first, repeated with optional idle gaps.
// All outputs are registered; captured inputs isolate a running burst from later input changes.
module pattern_tx #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap,
    output logic             data_out,
    output logic             valid_out,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(PAT_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(PAT_W);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] sh_q, sh_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             data_q, data_d;
    logic             valid_q, valid_d;
    logic             fs_q, fs_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             load_rep;
    logic [PAT_W-1:0] rep_src;

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        sh_d      = sh_q;
        bit_cnt_d = bit_cnt_q;
        rep_d     = rep_q;
        gap_len_d = gap_len_q;
        gap_cnt_d = gap_cnt_q;
        data_d    = 1'b0;
        valid_d   = 1'b0;
        fs_d      = 1'b0;
        done_d    = 1'b0;
        load_rep  = 1'b0;
        rep_src   = pat_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d     = pattern;
                    rep_d     = repeat_cnt;
                    gap_len_d = gap;
                    rep_src   = pattern;
                    load_rep  = 1'b1;
                end
            end
            SEND: begin
                if (bit_cnt_q != LAST_BIT) begin
                    data_d    = sh_q[PAT_W-1];
                    valid_d   = 1'b1;
                    sh_d      = {sh_q[PAT_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end else if (rep_q == '0) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    bit_cnt_d = '0;
                end else begin
                    rep_d = rep_q - CNT_W'(1);
                    if (gap_len_q == '0) begin
                        load_rep = 1'b1;
                    end else begin
                        // This cycle is already the first idle cycle of the gap.
                        state_d   = GAP;
                        gap_cnt_d = GAP_W'(1);
                        bit_cnt_d = '0;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == gap_len_q) begin
                    gap_cnt_d = '0;
                    load_rep  = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            DONE: begin
                state_d   = IDLE;
                pat_d     = '0;
                sh_d      = '0;
                gap_len_d = '0;
            end
            default: state_d = IDLE;
        endcase

        // Launch a repetition: MSB goes out now, remaining bits wait in the shifter.
        if (load_rep) begin
            state_d   = SEND;
            data_d    = rep_src[PAT_W-1];
            valid_d   = 1'b1;
            fs_d      = 1'b1;
            sh_d      = {rep_src[PAT_W-2:0], 1'b0};
            bit_cnt_d = BW'(1);
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            sh_q      <= '0;
            bit_cnt_q <= '0;
            rep_q     <= '0;
            gap_len_q <= '0;
            gap_cnt_q <= '0;
            data_q    <= 1'b0;
            valid_q   <= 1'b0;
            fs_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            sh_q      <= sh_d;
            bit_cnt_q <= bit_cnt_d;
            rep_q     <= rep_d;
            gap_len_q <= gap_len_d;
            gap_cnt_q <= gap_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            fs_q      <= fs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign frame_start = fs_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: doc/pattern_tx.md
PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter PAT_W, default 3, SHALL set the pattern width in bits (legal 2..32).
REQ-003 Parameter CNT_W, default 4, SHALL set the repeat-count width.
REQ-004 Parameter GAP_W, default 4, SHALL set the gap-length width.
REQ-005 Port clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-006 Port rst  input  1  SHALL be the asynchronous active-high reset.
REQ-007 Port start  input  1  SHALL request a burst; sampled only in IDLE.
REQ-008 Port pattern  input  PAT_W  SHALL be the bit pattern to serialize, MSB first.
REQ-009 Port repeat_cnt  input  CNT_W  SHALL give repetitions minus one (0 = one repetition).
REQ-010 Port gap  input  GAP_W  SHALL give the idle cycles inserted between repetitions.
REQ-011 Port data_out  output  1  SHALL be the serial bit stream.
REQ-012 Port valid_out  output  1  SHALL mark cycles where data_out carries a pattern bit.
REQ-013 Port frame_start  output  1  SHALL pulse with the first (MSB) bit of every repetition.
REQ-014 Port busy  output  1  SHALL be high in every state except IDLE.
REQ-015 Port done  output  1  SHALL pulse for one cycle after the last bit of the burst.

Function
REQ-016 The FSM SHALL have states IDLE, SEND, GAP, DONE; all outputs SHALL be registered.
REQ-017 IDLE: start=1 at an edge SHALL capture pattern, repeat_cnt, gap into internal registers and enter SEND; data_out=pattern MSB, valid_out=1, frame_start=1 in the next cycle.
REQ-018 Input changes after capture SHALL NOT affect the burst in progress.
REQ-019 SEND SHALL emit one bit per cycle, MSB to LSB, PAT_W cycles per repetition, valid_out=1.
REQ-020 After the LSB, with repetitions remaining and captured gap>0: GAP for exactly gap cycles, data_out=0, valid_out=0.
REQ-021 After the LSB, with repetitions remaining and captured gap=0: the next repetition's MSB SHALL follow in the immediately next cycle (no bubble).
REQ-022 After the last repetition's LSB: DONE for one cycle (done=1, valid_out=0, data_out=0), then IDLE.
REQ-023 GAP SHALL return to SEND with frame_start=1 on the first bit.
REQ-024 start while busy=1 (including the DONE cycle) SHALL be ignored and not queued.
REQ-025 Bit and gap counters SHALL not wrap: repeat_cnt=2^CNT_W-1 yields exactly 2^CNT_W repetitions; gap=2^GAP_W-1 yields exactly that many idle cycles.
REQ-026 Total cycles from first valid bit to done, inclusive, SHALL be (repeat_cnt+1)*PAT_W + repeat_cnt*gap + 1.

Reset
REQ-027 rst=1 SHALL immediately (asynchronously) force IDLE and data_out=0, valid_out=0, frame_start=0, busy=0, done=0, all counters and captured registers 0.
REQ-028 rst asserted mid-burst SHALL abort it with no done pulse; after release, the block SHALL accept a new start normally.
REQ-029 start held high while rst=1 SHALL have no effect; the first edge with rst=0 and start=1 SHALL start a burst.

Verification
REQ-030 PAT_W=3, pattern=101, repeat_cnt=0, gap=0, start pulse -> data_out 1,0,1 with valid_out=1 for 3 cycles, frame_start on cycle 1, done on cycle 4, busy low from cycle 5.
REQ-031 pattern=101, repeat_cnt=1, gap=2 -> data/valid: 1/1,0/1,1/1,0/0,0/0,1/1,0/1,1/1, then done; frame_start on cycles 1 and 6.
REQ-032 pattern=101, repeat_cnt=2, gap=0 -> 101101101 with valid_out continuously high for 9 cycles, done on cycle 10.
REQ-033 Burst with pattern=110; change pattern to 011 and pulse start mid-burst -> stream remains 110, no second burst; start pulsed in the DONE cycle is also ignored.
REQ-034 Assert rst during the second bit of a burst -> all outputs 0 immediately, no done pulse; release, start with pattern=111 -> 1,1,1 then done.
REQ-035 Random pattern, repeat_cnt and gap over 1000 bursts -> serial stream matches the scoreboard and the REQ-026 cycle count, and a 101 detector fed data_out counts the expected matches.
